mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/arb_priority_sel.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/LS memory port arbiter: exception codes and FSM state encodings.
package mem_port_arbiter_pkg;

  localparam int EXCEPTION_LEN = 4;
  typedef logic [EXCEPTION_LEN-1:0] exc_t;

  localparam exc_t EXC_NONE            = 4'h0;
  localparam exc_t EXC_FETCH_FAULT     = 4'h1;
  localparam exc_t EXC_LOAD_MISALIGNED = 4'h4;
  localparam exc_t EXC_LOAD_FAULT      = 4'h5;
  localparam exc_t EXC_STORE_FAULT     = 4'h7;

  localparam logic [2:0] ARB_IDLE    = 3'd0;
  localparam logic [2:0] ARB_BUSY_IF = 3'd1;
  localparam logic [2:0] ARB_BUSY_LS = 3'd2;
  localparam logic [2:0] ARB_DRAIN   = 3'd3;
  localparam logic [2:0] ARB_RESP    = 3'd4;

  function automatic logic arb_is_busy(input logic [2:0] state);
    return (state == ARB_BUSY_IF) || (state == ARB_BUSY_LS) || (state == ARB_DRAIN);
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Grant decision for the memory port arbiter. ARB_STARVE_GUARD_EN adds a counter that
// forces an IF grant after STARVE_MAX consecutive LS grants made while IF was waiting.
module arb_priority_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic ls_req,
  input  logic if_req,
  input  logic if_cancel,
  output logic grant_ls,
  output logic grant_if
);

  logic if_eligible;
  assign if_eligible = if_req && !if_cancel;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt_q, starve_cnt_d;
  logic       if_wins;

  assign if_wins  = if_eligible && (starve_cnt_q == 3'(STARVE_MAX));
  assign grant_if = arb_en && if_eligible && (if_wins || !ls_req);
  assign grant_ls = arb_en && ls_req && !if_wins;

  // Saturates so a cancelled fetch at the limit cannot wrap the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if) begin
      starve_cnt_d = 3'd0;
    end else if (grant_ls && if_req && (starve_cnt_q != 3'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 3'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  localparam int unused_starve_max = STARVE_MAX;
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign grant_ls = arb_en && ls_req;
  assign grant_if = arb_en && if_eligible && !ls_req;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, LS priority by default.
// Optional IF anti-starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req_In,
  input  logic [ADDR_W-1:0]        if_addr_In,
  input  logic                     if_cancel_In,
  output logic [DATA_W-1:0]        if_rdata_Out,
  output logic                     if_valid_Out,
  output logic [EXCEPTION_LEN-1:0] if_exc_Out,
  input  logic                     ls_req_In,
  input  logic [ADDR_W-1:0]        ls_addr_In,
  input  logic                     ls_we_In,
  input  logic [DATA_W-1:0]        ls_wdata_In,
  input  logic [3:0]               ls_wstrb_In,
  output logic [DATA_W-1:0]        ls_rdata_Out,
  output logic                     ls_valid_Out,
  output logic [EXCEPTION_LEN-1:0] ls_exc_Out,
  output logic                     mem_req_Out,
  output logic [ADDR_W-1:0]        mem_addr_Out,
  output logic                     mem_we_Out,
  output logic [DATA_W-1:0]        mem_wdata_Out,
  output logic [3:0]               mem_wstrb_Out,
  input  logic [DATA_W-1:0]        mem_rdata_In,
  input  logic                     mem_valid_In,
  input  logic [EXCEPTION_LEN-1:0] mem_exc_In
);

  logic [2:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_valid_q, if_valid_d;
  exc_t              if_exc_q, if_exc_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              ls_valid_q, ls_valid_d;
  exc_t              ls_exc_q, ls_exc_d;

  logic grant_ls, grant_if;

  arb_priority_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (state_q == ARB_IDLE),
    .ls_req    (ls_req_In),
    .if_req    (if_req_In),
    .if_cancel (if_cancel_In),
    .grant_ls  (grant_ls),
    .grant_if  (grant_if)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    if_exc_d    = if_exc_q;
    ls_rdata_d  = ls_rdata_q;
    ls_valid_d  = 1'b0;
    ls_exc_d    = ls_exc_q;

    case (state_q)
      ARB_IDLE: begin
        if (grant_ls) begin
          state_d     = ARB_BUSY_LS;
          mem_req_d   = 1'b1;
          mem_addr_d  = ls_addr_In;
          mem_we_d    = ls_we_In;
          mem_wdata_d = ls_wdata_In;
          mem_wstrb_d = ls_wstrb_In;
        end else if (grant_if) begin
          state_d     = ARB_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_addr_d  = if_addr_In;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          mem_wstrb_d = 4'h0;
        end
      end
      ARB_BUSY_IF: begin
        if (mem_valid_In) begin
          mem_req_d = 1'b0;
          // A flush landing with the response drops it and skips the response cycle.
          if (if_cancel_In) begin
            state_d = ARB_IDLE;
          end else begin
            state_d    = ARB_RESP;
            if_rdata_d = mem_rdata_In;
            if_exc_d   = mem_exc_In;
            if_valid_d = 1'b1;
          end
        end else if (if_cancel_In) begin
          state_d = ARB_DRAIN;
        end
      end
      ARB_BUSY_LS: begin
        if (mem_valid_In) begin
          mem_req_d  = 1'b0;
          state_d    = ARB_RESP;
          ls_rdata_d = mem_rdata_In;
          ls_exc_d   = mem_exc_In;
          ls_valid_d = 1'b1;
        end
      end
      ARB_DRAIN: begin
        // The memory still owes a response for the flushed fetch; swallow it.
        if (mem_valid_In) begin
          mem_req_d = 1'b0;
          state_d   = ARB_IDLE;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'h0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      if_exc_q    <= EXC_NONE;
      ls_rdata_q  <= '0;
      ls_valid_q  <= 1'b0;
      ls_exc_q    <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      if_exc_q    <= if_exc_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_valid_q  <= ls_valid_d;
      ls_exc_q    <= ls_exc_d;
    end
  end

  assign mem_req_Out   = mem_req_q;
  assign mem_addr_Out  = mem_addr_q;
  assign mem_we_Out    = mem_we_q;
  assign mem_wdata_Out = mem_wdata_q;
  assign mem_wstrb_Out = mem_wstrb_q;
  assign if_rdata_Out  = if_rdata_q;
  assign if_valid_Out  = if_valid_q;
  assign if_exc_Out    = if_exc_q;
  assign ls_rdata_Out  = ls_rdata_q;
  assign ls_valid_Out  = ls_valid_q;
  assign ls_exc_Out    = ls_exc_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after each rising edge, outputs
// are checked at the same point; the memory side is driven by hand in each step.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req_In;
  logic [31:0] if_addr_In;
  logic        if_cancel_In;
  logic [31:0] if_rdata_Out;
  logic        if_valid_Out;
  logic [3:0]  if_exc_Out;
  logic        ls_req_In;
  logic [31:0] ls_addr_In;
  logic        ls_we_In;
  logic [31:0] ls_wdata_In;
  logic [3:0]  ls_wstrb_In;
  logic [31:0] ls_rdata_Out;
  logic        ls_valid_Out;
  logic [3:0]  ls_exc_Out;
  logic        mem_req_Out;
  logic [31:0] mem_addr_Out;
  logic        mem_we_Out;
  logic [31:0] mem_wdata_Out;
  logic [3:0]  mem_wstrb_Out;
  logic [31:0] mem_rdata_In;
  logic        mem_valid_In;
  logic [3:0]  mem_exc_In;

  int vectors;
  int miscompares;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_In     (if_req_In),
    .if_addr_In    (if_addr_In),
    .if_cancel_In  (if_cancel_In),
    .if_rdata_Out  (if_rdata_Out),
    .if_valid_Out  (if_valid_Out),
    .if_exc_Out    (if_exc_Out),
    .ls_req_In     (ls_req_In),
    .ls_addr_In    (ls_addr_In),
    .ls_we_In      (ls_we_In),
    .ls_wdata_In   (ls_wdata_In),
    .ls_wstrb_In   (ls_wstrb_In),
    .ls_rdata_Out  (ls_rdata_Out),
    .ls_valid_Out  (ls_valid_Out),
    .ls_exc_Out    (ls_exc_Out),
    .mem_req_Out   (mem_req_Out),
    .mem_addr_Out  (mem_addr_Out),
    .mem_we_Out    (mem_we_Out),
    .mem_wdata_Out (mem_wdata_Out),
    .mem_wstrb_Out (mem_wstrb_Out),
    .mem_rdata_In  (mem_rdata_In),
    .mem_valid_In  (mem_valid_In),
    .mem_exc_In    (mem_exc_In)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  int  ls_grants;
  int  if_grants;
  logic prev_req;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    if_req_In    = 1'b0;
    if_addr_In   = '0;
    if_cancel_In = 1'b0;
    ls_req_In    = 1'b0;
    ls_addr_In   = '0;
    ls_we_In     = 1'b0;
    ls_wdata_In  = '0;
    ls_wstrb_In  = 4'h0;
    mem_rdata_In = '0;
    mem_valid_In = 1'b0;
    mem_exc_In   = EXC_NONE;

    step();
    step();
    chk("rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
    chk("rst_mem_req", 64'(mem_req_Out), 64'h0);
    chk("rst_if_valid", 64'(if_valid_Out), 64'h0);
    chk("rst_ls_valid", 64'(ls_valid_Out), 64'h0);
    chk("rst_if_exc", 64'(if_exc_Out), 64'(EXC_NONE));
    chk("rst_ls_exc", 64'(ls_exc_Out), 64'(EXC_NONE));
    rst = 1'b0;
    step();

    // IF-only fetch of 0x10, two wait cycles, response 0x13 on the 5th cycle.
    if_req_In = 1'b1; if_addr_In = 32'h10;
    step();
    chk("t1_state_busy_if", 64'(dut.state_q), 64'(ARB_BUSY_IF));
    chk("t1_mem_req", 64'(mem_req_Out), 64'h1);
    chk("t1_mem_addr", 64'(mem_addr_Out), 64'h10);
    chk("t1_mem_we", 64'(mem_we_Out), 64'h0);
    step();
    chk("t1_wait1_req", 64'(mem_req_Out), 64'h1);
    chk("t1_wait1_if_valid", 64'(if_valid_Out), 64'h0);
    step();
    chk("t1_wait2_req", 64'(mem_req_Out), 64'h1);
    mem_valid_In = 1'b1; mem_rdata_In = 32'h13;
    step();
    chk("t1_if_valid", 64'(if_valid_Out), 64'h1);
    chk("t1_if_rdata", 64'(if_rdata_Out), 64'h13);
    chk("t1_if_exc", 64'(if_exc_Out), 64'(EXC_NONE));
    chk("t1_ls_valid", 64'(ls_valid_Out), 64'h0);
    chk("t1_mem_req_drop", 64'(mem_req_Out), 64'h0);
    chk("t1_state_resp", 64'(dut.state_q), 64'(ARB_RESP));
    mem_valid_In = 1'b0; if_req_In = 1'b0;
    step();
    chk("t1_if_valid_pulse", 64'(if_valid_Out), 64'h0);
    chk("t1_state_idle", 64'(dut.state_q), 64'(ARB_IDLE));

    // Simultaneous IF and LS requests: LS store goes first, IF after the response cycle.
    if_req_In = 1'b1; if_addr_In = 32'h40;
    ls_req_In = 1'b1; ls_addr_In = 32'h100; ls_we_In = 1'b1;
    ls_wdata_In = 32'hDEADBEEF; ls_wstrb_In = 4'hF;
    step();
    chk("t2_state_busy_ls", 64'(dut.state_q), 64'(ARB_BUSY_LS));
    chk("t2_mem_we", 64'(mem_we_Out), 64'h1);
    chk("t2_mem_addr", 64'(mem_addr_Out), 64'h100);
    chk("t2_mem_wdata", 64'(mem_wdata_Out), 64'hDEADBEEF);
    chk("t2_mem_wstrb", 64'(mem_wstrb_Out), 64'hF);
    mem_valid_In = 1'b1; mem_rdata_In = 32'h0;
    step();
    chk("t2_ls_valid", 64'(ls_valid_Out), 64'h1);
    chk("t2_if_valid_none", 64'(if_valid_Out), 64'h0);
    ls_req_In = 1'b0; ls_we_In = 1'b0; mem_valid_In = 1'b0;
    step();
    chk("t2_resp_no_grant", 64'(mem_req_Out), 64'h0);
    chk("t2_ls_valid_pulse", 64'(ls_valid_Out), 64'h0);
    chk("t2_state_idle", 64'(dut.state_q), 64'(ARB_IDLE));
    step();
    chk("t2_state_busy_if", 64'(dut.state_q), 64'(ARB_BUSY_IF));
    chk("t2_if_addr", 64'(mem_addr_Out), 64'h40);
    chk("t2_if_we", 64'(mem_we_Out), 64'h0);
    chk("t2_if_wstrb", 64'(mem_wstrb_Out), 64'h0);
    mem_valid_In = 1'b1; mem_rdata_In = 32'h11223344;
    step();
    chk("t2_if_valid", 64'(if_valid_Out), 64'h1);
    chk("t2_if_rdata", 64'(if_rdata_Out), 64'h11223344);
    chk("t2_ls_valid_quiet", 64'(ls_valid_Out), 64'h0);
    if_req_In = 1'b0; mem_valid_In = 1'b0;
    step();
    chk("t2_if_valid_pulse", 64'(if_valid_Out), 64'h0);

    // Flush one cycle after the IF grant; late response is drained and swallowed.
    if_req_In = 1'b1; if_addr_In = 32'h30;
    step();
    chk("t3_state_busy_if", 64'(dut.state_q), 64'(ARB_BUSY_IF));
    if_cancel_In = 1'b1; if_req_In = 1'b0;
    step();
    chk("t3_state_drain", 64'(dut.state_q), 64'(ARB_DRAIN));
    chk("t3_drain_req", 64'(mem_req_Out), 64'h1);
    if_cancel_In = 1'b0;
    step();
    chk("t3_drain_hold", 64'(dut.state_q), 64'(ARB_DRAIN));
    step();
    chk("t3_drain_no_valid", 64'(if_valid_Out), 64'h0);
    mem_valid_In = 1'b1; mem_rdata_In = 32'hBAD0BAD0;
    step();
    chk("t3_state_idle", 64'(dut.state_q), 64'(ARB_IDLE));
    chk("t3_no_if_valid", 64'(if_valid_Out), 64'h0);
    chk("t3_mem_req_drop", 64'(mem_req_Out), 64'h0);
    mem_valid_In = 1'b0;
    if_req_In = 1'b1; if_addr_In = 32'h20;
    step();
    chk("t3_refetch_addr", 64'(mem_addr_Out), 64'h20);
    mem_valid_In = 1'b1; mem_rdata_In = 32'h55;
    step();
    chk("t3_refetch_valid", 64'(if_valid_Out), 64'h1);
    chk("t3_refetch_rdata", 64'(if_rdata_Out), 64'h55);
    if_req_In = 1'b0; mem_valid_In = 1'b0;
    step();

    // Misaligned LS load: exception goes to LS only.
    ls_req_In = 1'b1; ls_addr_In = 32'h101; ls_we_In = 1'b0; ls_wstrb_In = 4'h0;
    step();
    chk("t4_mem_we", 64'(mem_we_Out), 64'h0);
    mem_valid_In = 1'b1; mem_exc_In = EXC_LOAD_MISALIGNED; mem_rdata_In = 32'h0;
    step();
    chk("t4_ls_valid", 64'(ls_valid_Out), 64'h1);
    chk("t4_ls_exc", 64'(ls_exc_Out), 64'(EXC_LOAD_MISALIGNED));
    chk("t4_if_exc", 64'(if_exc_Out), 64'(EXC_NONE));
    ls_req_In = 1'b0; mem_valid_In = 1'b0; mem_exc_In = EXC_NONE;
    step();

    // Flush coinciding with the response: dropped, straight back to IDLE.
    if_req_In = 1'b1; if_addr_In = 32'h44;
    step();
    if_cancel_In = 1'b1; mem_valid_In = 1'b1; mem_rdata_In = 32'h77;
    step();
    chk("t5_same_cycle_idle", 64'(dut.state_q), 64'(ARB_IDLE));
    chk("t5_same_cycle_no_valid", 64'(if_valid_Out), 64'h0);
    mem_valid_In = 1'b0;
    // Cancel held in IDLE blocks the fetch grant.
    step();
    chk("t5_cancel_blocks", 64'(mem_req_Out), 64'h0);
    if_cancel_In = 1'b0;
    step();
    chk("t5_grant_after_cancel", 64'(dut.state_q), 64'(ARB_BUSY_IF));
    mem_valid_In = 1'b1; mem_rdata_In = 32'h88;
    step();
    chk("t5_valid", 64'(if_valid_Out), 64'h1);
    if_req_In = 1'b0; mem_valid_In = 1'b0;
    step();

    // Reset in BUSY_LS abandons the transaction and restores exc outputs.
    ls_req_In = 1'b1; ls_addr_In = 32'h180;
    step();
    chk("t6_busy_ls", 64'(dut.state_q), 64'(ARB_BUSY_LS));
    rst = 1'b1;
    step();
    chk("t6_rst_req", 64'(mem_req_Out), 64'h0);
    chk("t6_rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
    chk("t6_rst_ls_valid", 64'(ls_valid_Out), 64'h0);
    chk("t6_rst_if_valid", 64'(if_valid_Out), 64'h0);
    chk("t6_rst_ls_exc", 64'(ls_exc_Out), 64'(EXC_NONE));
    rst = 1'b0; ls_req_In = 1'b0;
    step();

    // Continuous LS traffic with IF pending, zero-wait memory.
    ls_req_In = 1'b1; ls_addr_In = 32'h200; ls_we_In = 1'b0;
    if_req_In = 1'b1; if_addr_In = 32'h300;
    ls_grants = 0; if_grants = 0; prev_req = 1'b0;
    for (int i = 0; i < 60 && if_grants == 0 && ls_grants < 6; i++) begin
      mem_valid_In = mem_req_Out;
      mem_rdata_In = 32'(i);
      step();
      if (mem_req_Out && !prev_req) begin
        if (mem_addr_Out == 32'h300) if_grants++;
        else ls_grants++;
      end
      prev_req = mem_req_Out;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("t7_ls_grants_before_if", 64'(ls_grants), 64'd4);
    chk("t7_if_granted", 64'(if_grants), 64'd1);
    chk("t7_state_busy_if", 64'(dut.state_q), 64'(ARB_BUSY_IF));
`else
    chk("t7_ls_grants", 64'(ls_grants), 64'd6);
    chk("t7_if_never_granted", 64'(if_grants), 64'd0);
    chk("t7_state_busy_ls", 64'(dut.state_q), 64'(ARB_BUSY_LS));
`endif
    ls_req_In = 1'b0; if_req_In = 1'b0;
    mem_valid_In = 1'b1; mem_rdata_In = 32'h99;
    step();
`ifdef ARB_STARVE_GUARD_EN
    chk("t7_if_valid", 64'(if_valid_Out), 64'h1);
`else
    chk("t7_ls_valid", 64'(ls_valid_Out), 64'h1);
`endif
    mem_valid_In = 1'b0;
    step();
    chk("t7_final_idle", 64'(dut.state_q), 64'(ARB_IDLE));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
